// File: rtl/hls_mult_arb_pkg.sv
// Shared types, default widths and the round-robin pick helper for hls_mult_arbiter.
package hls_mult_arb_pkg;

  localparam int DEF_NREQ = 4;
  localparam int DEF_DW   = 32;
  localparam int DEF_RW   = 64;
  localparam int MAX_NREQ = 16;
  localparam int PTR_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or above ptr, wrapping at nreq (ptr must be < nreq).
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                       input logic [PTR_W-1:0]    ptr,
                                       input int                  nreq);
    rr_pick_t res;
    int       j;
    res = '0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      if (k < nreq) begin
        j = int'(ptr) + k;
        if (j >= nreq) j = j - nreq;
        if (!res.found && valid[j[PTR_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j[PTR_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hls_mult_arbiter_rr_arbiter.sv
// Combinational round-robin priority selector: one-hot grant plus binary index.
module rr_arbiter
  import hls_mult_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_found
);

  rr_pick_t w_pick;

  assign w_pick  = rr_pick(MAX_NREQ'(i_req), PTR_W'(i_ptr), NREQ);
  assign o_idx   = w_pick.idx[IW-1:0];
  assign o_found = w_pick.found;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
      assign o_gnt[gi] = w_pick.found && (w_pick.idx == PTR_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/hls_mult_arbiter.sv
// Round-robin sharing of one ap_ctrl_hs multiplier among NREQ requesters.
// Optional statistics counters are enabled by defining HLS_MULT_ARB_STATS_EN.
module hls_mult_arbiter
  import hls_mult_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW   = DEF_DW,
  parameter int RW   = DEF_RW
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [NREQ-1:0]    resp_valid,
  input  logic [NREQ-1:0]    resp_ready,
  output logic [RW-1:0]      resp_data,
  output logic               mul_ap_start,
  input  logic               mul_ap_ready,
  input  logic               mul_ap_done,
  input  logic               mul_ap_idle,
  output logic [DW-1:0]      mul_a,
  output logic [DW-1:0]      mul_b,
  input  logic [RW-1:0]      mul_ap_return
`ifdef HLS_MULT_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] stat_grant_cnt,
  output logic [31:0]        stat_busy_cycles
`endif
);

  localparam int IW = $clog2(NREQ);

  arb_state_e      r_state, w_state_next;
  logic [IW-1:0]   r_rr_ptr, r_gnt_idx, w_pick_idx;
  logic [NREQ-1:0] w_pick_gnt;
  logic            w_pick_found;
  logic [DW-1:0]   r_a, r_b;
  logic [RW-1:0]   r_result;
  logic            r_cool;
  logic            w_accept, w_capture, w_resp_take;
  logic [DW-1:0]   w_req_a_arr [NREQ];
  logic [DW-1:0]   w_req_b_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
      assign w_req_a_arr[gi] = req_a[gi*DW +: DW];
      assign w_req_b_arr[gi] = req_b[gi*DW +: DW];
    end
  endgenerate

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= IDLE;
    else           r_state <= w_state_next;
  end

  // r_cool blocks a grant in the first IDLE cycle after a response completes.
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    resp_valid   = '0;
    mul_ap_start = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_resp_take  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_found && mul_ap_idle && !r_cool) begin
          req_ready    = w_pick_gnt;
          w_accept     = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        mul_ap_start = 1'b1;
        if (mul_ap_ready) begin
          if (mul_ap_done) begin
            w_capture    = 1'b1;
            w_state_next = RESP;
          end else begin
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (mul_ap_done) begin
          w_capture    = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        resp_valid[r_gnt_idx] = 1'b1;
        if (resp_ready[r_gnt_idx]) begin
          w_resp_take  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rr_ptr  <= '0;
      r_gnt_idx <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_cool    <= 1'b0;
    end else begin
      r_cool <= w_resp_take;
      if (w_accept) begin
        r_gnt_idx <= w_pick_idx;
        r_a       <= w_req_a_arr[w_pick_idx];
        r_b       <= w_req_b_arr[w_pick_idx];
      end
      if (w_capture) r_result <= mul_ap_return;
      if (w_resp_take) begin
        r_rr_ptr <= (r_gnt_idx == IW'(NREQ-1)) ? '0 : r_gnt_idx + 1'b1;
      end
    end
  end

  assign mul_a     = r_a;
  assign mul_b     = r_b;
  assign resp_data = r_result;

`ifdef HLS_MULT_ARB_STATS_EN
  logic [15:0] r_grant_cnt [NREQ];
  logic [31:0] r_busy_cycles;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_grant_cnt[gi] <= '0;
        else if (req_ready[gi] && (r_grant_cnt[gi] != 16'hFFFF))
          r_grant_cnt[gi] <= r_grant_cnt[gi] + 16'd1;
      end
      assign stat_grant_cnt[gi*16 +: 16] = r_grant_cnt[gi];
    end
  endgenerate

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_busy_cycles <= '0;
    else if ((r_state != IDLE) && (r_busy_cycles != 32'hFFFF_FFFF))
      r_busy_cycles <= r_busy_cycles + 32'd1;
  end

  assign stat_busy_cycles = r_busy_cycles;
`endif

endmodule

// File: tb/tb_hls_mult_arbiter.sv
// Scoreboard bench for hls_mult_arbiter with a behavioural ap_ctrl_hs multiplier.
module tb_hls_mult_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int RW   = 64;

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a = '0;
  logic [NREQ*DW-1:0] req_b = '0;
  logic [NREQ-1:0]    resp_valid;
  logic [NREQ-1:0]    resp_ready = '1;
  logic [RW-1:0]      resp_data;
  logic               mul_ap_start, mul_ap_ready, mul_ap_done, mul_ap_idle;
  logic [DW-1:0]      mul_a, mul_b;
  logic [RW-1:0]      mul_ap_return;
`ifdef HLS_MULT_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_grant_cnt;
  logic [31:0]        stat_busy_cycles;
`endif

  always #5 ap_clk = ~ap_clk;

  hls_mult_arbiter #(.NREQ(NREQ), .DW(DW), .RW(RW)) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .mul_ap_start  (mul_ap_start),
    .mul_ap_ready  (mul_ap_ready),
    .mul_ap_done   (mul_ap_done),
    .mul_ap_idle   (mul_ap_idle),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_ap_return (mul_ap_return)
`ifdef HLS_MULT_ARB_STATS_EN
    ,
    .stat_grant_cnt   (stat_grant_cnt),
    .stat_busy_cycles (stat_busy_cycles)
`endif
  );

  // Behavioural multiplier: lat==1 means ap_ready and ap_done in the same cycle.
  int          lat = 3;
  logic        spur = 1'b0;
  logic        m_busy;
  logic [3:0]  m_cnt;
  logic [RW-1:0] m_res;

  assign mul_ap_idle   = !m_busy;
  assign mul_ap_ready  = mul_ap_start && !m_busy;
  assign mul_ap_done   = spur || ((lat == 1) ? mul_ap_ready : (m_busy && m_cnt == 4'd1));
  assign mul_ap_return = (lat == 1) ? (64'(mul_a) * 64'(mul_b)) : m_res;

  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
      m_res  <= '0;
    end else if (mul_ap_ready && lat > 1) begin
      m_busy <= 1'b1;
      m_cnt  <= 4'(lat - 1);
      m_res  <= 64'(mul_a) * 64'(mul_b);
    end else if (m_busy) begin
      m_cnt <= m_cnt - 4'd1;
      if (m_cnt == 4'd1) m_busy <= 1'b0;
    end
  end

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } exp_t;

  exp_t        sb[$];
  int          g_log[$];
  int          g_cyc[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  int          tb_ptr = 0;
  int          busy_model = 0;
  bit          in_op = 0;
  int          pend[NREQ];
  logic [31:0] opa[NREQ];
  logic [31:0] opb[NREQ];
  bit          acc_seen[NREQ];
  int          rdy_cnt[NREQ];
  logic [63:0] last_data = '0;
  int          mon_gi, mon_ri;
  exp_t        mon_e;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Requester model: holds a request while ops are pending, refreshes operands after each accept.
  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0; opa[i] = '0; opb[i] = '0; acc_seen[i] = 0; rdy_cnt[i] = 0;
    end
    forever begin
      @(posedge ap_clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc_seen[i]) begin
          acc_seen[i] = 0;
          if (pend[i] > 0) pend[i]--;
          opa[i] = $urandom;
          opb[i] = $urandom;
        end
        req_valid[i]         = (pend[i] > 0);
        req_a[i*DW +: DW]    = opa[i];
        req_b[i*DW +: DW]    = opb[i];
      end
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (in_op) busy_model++;
      if (req_ready != '0) begin
        mon_gi = 0;
        for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) mon_gi = i;
        check_eq("req_ready_onehot", $countones(req_ready), 1);
        check_eq("grant_idx", mon_gi, model_pick(req_valid, tb_ptr));
        mon_e.idx  = mon_gi;
        mon_e.a    = opa[mon_gi];
        mon_e.b    = opb[mon_gi];
        mon_e.prod = 64'(opa[mon_gi]) * 64'(opb[mon_gi]);
        sb.push_back(mon_e);
        g_log.push_back(mon_gi);
        g_cyc.push_back(cyc);
        acc_seen[mon_gi] = 1;
        rdy_cnt[mon_gi]++;
        in_op = 1;
      end
      if (mul_ap_start) begin
        if (sb.size() == 0) check_eq("start_without_grant", sb.size(), 1);
        else begin
          check_eq("mul_a", mul_a, sb[0].a);
          check_eq("mul_b", mul_b, sb[0].b);
        end
      end
      if (resp_valid != '0) begin
        mon_ri = 0;
        for (int i = NREQ - 1; i >= 0; i--) if (resp_valid[i]) mon_ri = i;
        check_eq("resp_valid_onehot", $countones(resp_valid), 1);
        if (sb.size() == 0) check_eq("resp_without_grant", sb.size(), 1);
        else begin
          check_eq("resp_idx", mon_ri, sb[0].idx);
          check_eq("resp_data", resp_data, sb[0].prod);
          if (resp_ready[mon_ri]) begin
            $display("t=%0t resp req=%0d a=0x%0h b=0x%0h data=0x%0h", $time, mon_ri,
                     sb[0].a, sb[0].b, resp_data);
            last_data = resp_data;
            void'(sb.pop_front());
            tb_ptr = (mon_ri + 1) % NREQ;
            in_op  = 0;
          end
        end
      end
    end
  end

  task automatic drain(input string tag, input int budget);
    int t = 0;
    bit ok = 0;
    while (t < budget && !ok) begin
      @(posedge ap_clk);
      #2;
      t++;
      ok = (pend[0] == 0) && (pend[1] == 0) && (pend[2] == 0) && (pend[3] == 0) &&
           (sb.size() == 0) && (resp_valid == '0) && !in_op;
    end
    check_eq({"drain_", tag}, ok, 1);
  endtask

  task automatic wait_resp(input int idx, input int budget);
    int t = 0;
    bit seen = 0;
    while (t < budget && !seen) begin
      @(negedge ap_clk);
      t++;
      seen = resp_valid[idx];
    end
    check_eq("wait_resp", seen, 1);
  endtask

  task automatic wait_start(input int budget);
    int t = 0;
    bit seen = 0;
    while (t < budget && !seen) begin
      @(negedge ap_clk);
      t++;
      seen = mul_ap_start;
    end
    check_eq("wait_start", seen, 1);
  endtask

  task automatic clear_bench();
    sb.delete();
    tb_ptr = 0; in_op = 0; busy_model = 0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0; acc_seen[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    clear_bench();
    repeat (2) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
  endtask

  initial begin
    int n;
    // Reset values
    repeat (3) @(negedge ap_clk);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_data", resp_data, 0);
    check_eq("rst_mul_start", mul_ap_start, 0);
    check_eq("rst_mul_a", mul_a, 0);
    check_eq("rst_mul_b", mul_b, 0);
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;

    // Spurious ap_done while idle must be ignored
    spur = 1'b1;
    repeat (3) begin
      @(negedge ap_clk);
      check_eq("spur_resp_valid", resp_valid, 0);
      check_eq("spur_mul_start", mul_ap_start, 0);
    end
    spur = 1'b0;

    // Single request from requester 2, 3-cycle multiplier
    lat = 3;
    opa[2] = 32'd7; opb[2] = 32'd6; pend[2] = 1;
    drain("single", 50);
    check_eq("single_rdy_pulses", rdy_cnt[2], 1);
    check_eq("single_data", last_data, 64'd42);

    // All four requesting continuously from reset
    do_reset();
    lat = 2;
    n = g_log.size();
    for (int i = 0; i < NREQ; i++) pend[i] = 2;
    drain("all4", 300);
    check_eq("all4_count", g_log.size() - n, 8);
    for (int k = 0; k < 8; k++) check_eq("all4_order", g_log[n + k], k % NREQ);

    // Single-cycle multiplier: 4-cycle turnaround
    lat = 1;
    n = g_cyc.size();
    pend[1] = 3;
    drain("lat1", 100);
    check_eq("lat1_count", g_cyc.size() - n, 3);
    check_eq("lat1_turn0", g_cyc[n + 1] - g_cyc[n], 4);
    check_eq("lat1_turn1", g_cyc[n + 2] - g_cyc[n + 1], 4);

    // Response back-pressure on requester 1
    lat = 2;
    @(posedge ap_clk);
    #2;
    resp_ready = 4'b1101;
    opa[1] = 32'd11; opb[1] = 32'd13; pend[1] = 1;
    wait_resp(1, 40);
    pend[0] = 1; pend[3] = 1;
    repeat (10) begin
      @(negedge ap_clk);
      check_eq("hold_resp_valid", resp_valid, 4'b0010);
      check_eq("hold_resp_data", resp_data, 64'd143);
      check_eq("hold_mul_start", mul_ap_start, 0);
      check_eq("hold_req_ready", req_ready, 0);
    end
    resp_ready = '1;
    drain("hold", 100);
    n = g_log.size();
    check_eq("hold_order_a", g_log[n - 3], 1);
    check_eq("hold_order_b", g_log[n - 2], 3);
    check_eq("hold_order_c", g_log[n - 1], 0);

    // Asynchronous reset in WAIT
    lat = 5;
    pend[2] = 1;
    wait_start(40);
    @(posedge ap_clk);
    @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_eq("arst_mul_start", mul_ap_start, 0);
    check_eq("arst_resp_valid", resp_valid, 0);
    check_eq("arst_req_ready", req_ready, 0);
    check_eq("arst_resp_data", resp_data, 0);
    check_eq("arst_mul_a", mul_a, 0);
    clear_bench();
    lat = 2;
    for (int i = 0; i < NREQ; i++) pend[i] = 1;
    n = g_log.size();
    repeat (2) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    drain("arst", 200);
    check_eq("arst_first_grant", g_log[n], 0);

`ifdef HLS_MULT_ARB_STATS_EN
    // Statistics: five ops from requester 3
    do_reset();
    lat = 3;
    pend[3] = 5;
    drain("stats", 200);
    check_eq("stat_grant3", stat_grant_cnt[3*16 +: 16], 16'd5);
    check_eq("stat_grant0", stat_grant_cnt[0 +: 16], 16'd0);
    check_eq("stat_busy", stat_busy_cycles, busy_model);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hls_mult_arbiter.md
# hls_mult_arbiter

Shares one `hls_multiplier` instance (ap_ctrl_hs block-level protocol) among `NREQ` requesters. Arbitration is round-robin, and one operation runs at a time. The block latches the winner's operands and drives the multiplier's `ap_start`/`ap_ready`/`ap_done` handshake. It captures `ap_return` and hands the product back to the winning requester over a valid/ready response channel. It sits between the requester fabric and the multiplier, and its handshake pins are what the dataflow monitor's module interface probes.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `DW`, 32: operand width.
- `RW`, 64: result width; must be ≥ `DW`.
- `ap_clk` in 1: single clock, rising edge.
- `ap_rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `NREQ`: per-requester operation request.
- `req_ready` out `NREQ`: one-hot accept pulse.
- `req_a`, `req_b` in `NREQ*DW`: packed per-requester operands.
- `resp_valid` out `NREQ`: one-hot, result available for that requester.
- `resp_ready` in `NREQ`: per-requester result accept.
- `resp_data` out `RW`: product, shared by all requesters.
- `mul_ap_start` out 1: to `hls_multiplier.ap_start`.
- `mul_ap_ready` in 1: from `hls_multiplier.ap_ready`.
- `mul_ap_done` in 1: from `hls_multiplier.ap_done`.
- `mul_ap_idle` in 1: from multiplier; used only for the start guard.
- `mul_a`, `mul_b` out `DW`: operands to the multiplier.
- `mul_ap_return` in `RW`: multiplier result.

## Operation
- FSM states: `IDLE`, `START`, `WAIT`, `RESP`.
- `IDLE`:
  - When any `req_valid` is high and `mul_ap_idle` is high, grant the first requester found searching from `rr_ptr` upward, modulo `NREQ`.
  - Pulse `req_ready[g]` for one cycle, combinationally from the registered state and inputs.
  - Latch `g`, `req_a[g]` and `req_b[g]`, then go to `START`.
- `START`:
  - `mul_ap_start=1`; `mul_a`/`mul_b` come from the latched operands and are held stable.
  - On `mul_ap_ready`: if `mul_ap_done` is high in the same cycle (single-cycle multiplier), capture `mul_ap_return` and go to `RESP`. Otherwise go to `WAIT`.
- `WAIT`: `mul_ap_start=0`; on `mul_ap_done`, capture `mul_ap_return` into `resp_data` and go to `RESP`.
- `RESP`:
  - `resp_valid[g]=1` and `resp_data` are held until `resp_ready[g]`.
  - On acceptance, set `rr_ptr = (g+1) mod NREQ` and go to `IDLE`.
- The granted requester's `req_valid` may drop after acceptance without effect. Requests arriving in a non-`IDLE` state wait.
- `mul_ap_done` outside `WAIT`/`START` is ignored (spurious). `resp_ready` for a non-granted index is ignored.
- Result is stored in full `RW` bits, with no truncation or extension done by this block.

## Timing
- Reset values: state `IDLE`, `rr_ptr=0`, `req_ready=0`, `resp_valid=0`, `resp_data=0`, `mul_ap_start=0`, `mul_a=mul_b=0`.
- Reset asserted mid-operation: all outputs go to reset values immediately, regardless of clock. The multiplier is reset by the same net, so no drain is needed.
- Handshake timeline:
  - Cycle 0: accept.
  - Cycle 1: `mul_ap_start` asserted.
  - Held until `mul_ap_ready`.
  - Result registered the cycle after `mul_ap_done`.
  - `resp_valid` rises one cycle after `mul_ap_done`.
- Minimum turnaround is 4 cycles per operation when the multiplier has 1-cycle latency and `resp_ready` is tied high. No back-to-back grant in the `RESP`→`IDLE` cycle.
- Fairness: a continuously requesting requester is granted within `NREQ` operations.

## Configuration
- `HLS_MULT_ARB_STATS_EN` defined adds two output port groups and their counters:
  - `stat_grant_cnt` (`NREQ*16`): per-requester grant counters, saturating at 16'hFFFF.
  - `stat_busy_cycles` (32): count of cycles not in `IDLE`, saturating at 32'hFFFF_FFFF.
  - Both are cleared by reset only.
- `HLS_MULT_ARB_STATS_EN` undefined: these ports and the counter logic are absent, and functional behaviour is identical.

## Structure
- Package `hls_mult_arb_pkg`:
  - State enum `arb_state_e`.
  - Default widths.
  - Function `rr_pick(valid, ptr)` returning index plus found flag.
- Sub-module `rr_arbiter`: combinational round-robin priority from `rr_ptr`, outputs one-hot grant and binary index. The FSM and operand/result registers stay in `hls_mult_arbiter`.

## Test plan
- Single request, requester 2, a=7, b=6, 3-cycle multiplier → `req_ready[2]` pulses once, `mul_a=7`/`mul_b=6` during `START`, then `resp_valid[2]` with `resp_data=42`.
- All 4 requesting continuously from reset → grant order 0,1,2,3,0 and each `resp_data` equals that requester's product.
- Single-cycle multiplier (`ap_ready` and `ap_done` together) → `START`→`RESP` directly, with 4-cycle turnaround.
- `resp_ready[1]` held low for 10 cycles → `resp_valid[1]`/`resp_data` stable, no new `mul_ap_start`, other requests stalled.
- `ap_rst_n` dropped during `WAIT` → `mul_ap_start`, `resp_valid` and `req_ready` are 0 immediately. After release, the first grant goes to requester 0.
- `HLS_MULT_ARB_STATS_EN` build, 5 ops by requester 3 → `stat_grant_cnt[3]=5`, and `stat_busy_cycles` equals the cycles counted by the bench outside `IDLE`.
